// File: rtl/uart_receiver.sv
// 8N1 UART receive engine: oversampled mid-bit sampling feeding a single-entry
// valid/ready output register with framing-error and overrun status pulses.
module uart_receiver #(
    parameter int CLOCK_FREQ = 1_600_000,
    parameter int BAUD_RATE  = 100_000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_data_ready,
    output logic       o_frame_error,
    output logic       o_overrun
);

    localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

    generate
        if (CLOCKS_PER_BIT < 4) begin : g_cpb_check
            $fatal(1, "uart_receiver: CLOCK_FREQ / BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             byte_done;
    logic             frame_err_pend;

    // Both flops reset high so an idle line never looks like a start bit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_idx        <= 3'd0;
            shift          <= 8'h00;
            byte_done      <= 1'b0;
            frame_err_pend <= 1'b0;
        end else begin
            byte_done      <= 1'b0;
            frame_err_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    // Half a bit in: a line that has gone high again was only a glitch.
                    if (cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt     <= '0;
                            bit_idx <= 3'd0;
                            state   <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            byte_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            frame_err_pend <= 1'b1;
                            state          <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A handshake in the completion cycle frees the slot, so that case is not an overrun.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_data        <= 8'h00;
            o_data_valid  <= 1'b0;
            o_frame_error <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_frame_error <= frame_err_pend;
            o_overrun     <= 1'b0;
            if (byte_done) begin
                if (!o_data_valid || i_data_ready) begin
                    o_data       <= shift;
                    o_data_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_data_valid && i_data_ready) begin
                o_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a frame table with hand-computed results plus
// glitch, break, overrun, same-cycle handshake and mid-frame reset sequences.
module tb_uart_receiver;

    localparam int CPB     = 16;
    localparam int LATENCY = 156;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       ready;
    logic       o_frame_error;
    logic       o_overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int valid_cycles = 0;
    int got_data[$];
    int got_cyc[$];
    int ferr_cyc[$];
    int ovr_cyc[$];
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_receiver #(
        .CLOCK_FREQ(1_600_000),
        .BAUD_RATE (100_000)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_uart_rx    (rx),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (ready),
        .o_frame_error(o_frame_error),
        .o_overrun    (o_overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Event log sampled mid-cycle; a byte is new when the slot was empty or just consumed.
    always @(negedge clock) begin
        if (o_data_valid && (!prev_valid || prev_ready)) begin
            got_data.push_back(int'(o_data));
            got_cyc.push_back(cyc);
        end
        if (o_data_valid) valid_cycles++;
        if (o_frame_error) ferr_cyc.push_back(cyc);
        if (o_overrun) ovr_cyc.push_back(cyc);
        prev_valid = o_data_valid;
        prev_ready = ready;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int extra_low);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
        if (!stop_bit && extra_low > 0) wait_cycles(extra_low);
        rx = 1'b1;
    endtask

    task automatic applyStimulus(input int idx);
        int b_data, b_ferr, b_ovr, b_vc, s;
        b_data = got_data.size();
        b_ferr = ferr_cyc.size();
        b_ovr  = ovr_cyc.size();
        b_vc   = valid_cycles;
        s      = cyc;
        send_frame(vecs[idx].data, vecs[idx].stop_bit, 0);
        wait_cycles(40);
        checkOutput($sformatf("vec%0d byte count", idx), got_data.size() - b_data, vecs[idx].exp_bytes);
        if (vecs[idx].exp_bytes == 1 && got_data.size() > b_data) begin
            checkOutput($sformatf("vec%0d data", idx), got_data[b_data], int'(vecs[idx].data));
            checkOutput($sformatf("vec%0d valid cycle", idx), got_cyc[b_data], s + LATENCY);
            checkOutput($sformatf("vec%0d valid width", idx), valid_cycles - b_vc, 1);
        end
        checkOutput($sformatf("vec%0d frame errors", idx), ferr_cyc.size() - b_ferr, vecs[idx].exp_ferr);
        if (vecs[idx].exp_ferr == 1 && ferr_cyc.size() > b_ferr)
            checkOutput($sformatf("vec%0d ferr cycle", idx), ferr_cyc[b_ferr], s + LATENCY);
        checkOutput($sformatf("vec%0d overruns", idx), ovr_cyc.size() - b_ovr, 0);
    endtask

    initial begin
        int b_data, b_ferr, b_ovr, s, s2;

        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'hC3, 1'b1, 1, 0};
        vecs[2] = '{8'h01, 1'b1, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 0};
        vecs[4] = '{8'h7E, 1'b0, 0, 1};
        vecs[5] = '{8'hFF, 1'b1, 1, 0};

        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset o_data", int'(o_data), 0);
        checkOutput("reset valid", int'(o_data_valid), 0);
        checkOutput("reset frame_error", int'(o_frame_error), 0);
        checkOutput("reset overrun", int'(o_overrun), 0);
        @(posedge clock);
        #2 reset = 1'b0;
        wait_cycles(5);

        for (int i = 0; i < 6; i++) applyStimulus(i);

        // Short low glitch must be rejected, then a real frame still decodes.
        b_data = got_data.size();
        b_ferr = ferr_cyc.size();
        b_ovr  = ovr_cyc.size();
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(40);
        checkOutput("glitch no byte", got_data.size() - b_data, 0);
        checkOutput("glitch no ferr", ferr_cyc.size() - b_ferr, 0);
        checkOutput("glitch no overrun", ovr_cyc.size() - b_ovr, 0);
        send_frame(8'hC3, 1'b1, 0);
        wait_cycles(40);
        checkOutput("after glitch count", got_data.size() - b_data, 1);
        if (got_data.size() > b_data) checkOutput("after glitch data", got_data[b_data], 'hC3);

        // Bad stop bit followed by a long break: a single error, then recovery.
        b_data = got_data.size();
        b_ferr = ferr_cyc.size();
        s = cyc;
        send_frame(8'h7E, 1'b0, 40 * CPB);
        wait_cycles(40);
        checkOutput("break ferr count", ferr_cyc.size() - b_ferr, 1);
        if (ferr_cyc.size() > b_ferr) checkOutput("break ferr cycle", ferr_cyc[b_ferr], s + LATENCY);
        checkOutput("break no byte", got_data.size() - b_data, 0);
        send_frame(8'hA3, 1'b1, 0);
        wait_cycles(40);
        checkOutput("post-break count", got_data.size() - b_data, 1);
        if (got_data.size() > b_data) checkOutput("post-break data", got_data[b_data], 'hA3);
        checkOutput("post-break o_data", int'(o_data), 'hA3);

        // Consumer stalled: the second byte is dropped with one overrun pulse.
        ready = 1'b0;
        b_data = got_data.size();
        b_ovr  = ovr_cyc.size();
        send_frame(8'h12, 1'b1, 0);
        s2 = cyc;
        send_frame(8'h34, 1'b1, 0);
        wait_cycles(40);
        checkOutput("overrun count", ovr_cyc.size() - b_ovr, 1);
        if (ovr_cyc.size() > b_ovr) checkOutput("overrun cycle", ovr_cyc[b_ovr], s2 + LATENCY);
        checkOutput("overrun new bytes", got_data.size() - b_data, 1);
        checkOutput("overrun keeps data", int'(o_data), 'h12);
        checkOutput("overrun valid held", int'(o_data_valid), 1);
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
        wait_cycles(2);
        checkOutput("consume drops valid", int'(o_data_valid), 0);

        // Handshake lands in the completion cycle: replace without overrun.
        b_ovr = ovr_cyc.size();
        send_frame(8'h12, 1'b1, 0);
        wait_cycles(10);
        checkOutput("pending 0x12", int'(o_data), 'h12);
        s = cyc;
        fork
            send_frame(8'h34, 1'b1, 0);
            begin
                wait_cycles(LATENCY - 1);
                ready = 1'b1;
                wait_cycles(1);
                ready = 1'b0;
            end
        join
        wait_cycles(20);
        checkOutput("same-cycle no overrun", ovr_cyc.size() - b_ovr, 0);
        checkOutput("same-cycle data", int'(o_data), 'h34);
        checkOutput("same-cycle valid", int'(o_data_valid), 1);

        // Reset during data bit 3 of 0x99 with 0x34 still pending.
        b_data = got_data.size();
        b_ferr = ferr_cyc.size();
        b_ovr  = ovr_cyc.size();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b1;
        wait_cycles(CPB / 2);
        reset = 1'b1;
        #1;
        checkOutput("mid-reset valid cleared", int'(o_data_valid), 0);
        checkOutput("mid-reset o_data", int'(o_data), 0);
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(10 * CPB);
        checkOutput("aborted frame no byte", got_data.size() - b_data, 0);
        checkOutput("aborted frame no ferr", ferr_cyc.size() - b_ferr, 0);

        // Back-to-back frames with no idle time between stop and start.
        ready = 1'b1;
        b_data = got_data.size();
        s = cyc;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        wait_cycles(40);
        checkOutput("b2b count", got_data.size() - b_data, 2);
        if (got_data.size() >= b_data + 2) begin
            checkOutput("b2b first data", got_data[b_data], 'h00);
            checkOutput("b2b first cycle", got_cyc[b_data], s + LATENCY);
            checkOutput("b2b second data", got_data[b_data + 1], 'hFF);
            checkOutput("b2b second cycle", got_cyc[b_data + 1], s + 10 * CPB + LATENCY);
        end
        checkOutput("b2b no ferr", ferr_cyc.size() - b_ferr, 0);
        checkOutput("b2b no overrun", ovr_cyc.size() - b_ovr, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
